// File: rtl/iob_uart_rx_deser.sv
// UART 8N1 receive deserializer: synchronizes rxd_i, samples mid-bit at div_i clocks/bit and
// presents bytes on a valid/ready port. Optional parity check when IOB_UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module iob_uart_rx_deser #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              rx_en_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              rxd_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              clr_i,
  output logic              overrun_o,
  output logic              frame_err_o
`ifdef IOB_UART_RX_PARITY_EN
  ,
  input  logic              par_en_i,
  input  logic              par_odd_i,
  output logic              par_err_o
`endif
);

  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef IOB_UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [1:0]        sync_reg;
  logic              rxd_s;
  logic [2:0]        state_reg;
  logic [DIV_W-1:0]  cnt_reg;
  logic [BCNT_W-1:0] bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              overrun_reg;
  logic              frame_err_reg;

  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  reload_val;
  logic [DIV_W-1:0]  half_val;
  logic              tick;
  logic              stop_sample;
  logic              deliver;
  logic              frame_evt;
  logic              overrun_evt;
  logic              accept;
  logic [2:0]        after_data;

  assign rxd_s       = sync_reg[1];
  assign div_eff     = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
  assign reload_val  = div_eff - DIV_W'(1);
  assign half_val    = div_eff >> 1;
  assign tick        = (cnt_reg == '0);
  assign stop_sample = rx_en_i && (state_reg == ST_STOP) && tick;
  assign deliver     = stop_sample && rxd_s;
  assign frame_evt   = stop_sample && !rxd_s;
  // A completing byte is only accepted if the output register is free or being drained now.
  assign overrun_evt = deliver && valid_reg && !ready_i;
  assign accept      = deliver && (!valid_reg || ready_i);

`ifdef IOB_UART_RX_PARITY_EN
  logic par_err_reg;
  logic par_evt;

  assign after_data = par_en_i ? ST_PARITY : ST_STOP;
  assign par_evt    = rx_en_i && (state_reg == ST_PARITY) && tick &&
                      ((^shift_reg) ^ rxd_s ^ par_odd_i);
  assign par_err_o  = par_err_reg;
`else
  assign after_data = ST_STOP;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg    <= 2'b11;
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (cke_i) begin
      sync_reg <= {sync_reg[0], rxd_i};
      if (!rx_en_i) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (!rxd_s) begin
              state_reg <= ST_START;
              cnt_reg   <= half_val;
            end
          end
          ST_START: begin
            if (tick) begin
              if (!rxd_s) begin
                state_reg   <= ST_DATA;
                cnt_reg     <= reload_val;
                bit_cnt_reg <= '0;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end
          end
          ST_DATA: begin
            if (tick) begin
              shift_reg <= {rxd_s, shift_reg[DATA_W-1:1]};
              cnt_reg   <= reload_val;
              if (bit_cnt_reg == BCNT_W'(DATA_W - 1)) begin
                state_reg <= after_data;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + BCNT_W'(1);
              end
            end else begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end
          end
`ifdef IOB_UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick) begin
              state_reg <= ST_STOP;
              cnt_reg   <= reload_val;
            end else begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end
          end
`endif
          ST_STOP: begin
            if (tick) begin
              state_reg <= ST_IDLE;
            end else begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // Output register and sticky flags; a set event outranks clr_i in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (cke_i) begin
      if (accept) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (valid_reg && ready_i) begin
        valid_reg <= 1'b0;
      end
      if (overrun_evt) begin
        overrun_reg <= 1'b1;
      end else if (clr_i) begin
        overrun_reg <= 1'b0;
      end
      if (frame_evt) begin
        frame_err_reg <= 1'b1;
      end else if (clr_i) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

`ifdef IOB_UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_err_reg <= 1'b0;
    end else if (cke_i) begin
      if (par_evt) begin
        par_err_reg <= 1'b1;
      end else if (clr_i) begin
        par_err_reg <= 1'b0;
      end
    end
  end
`endif

  assign data_o      = data_reg;
  assign valid_o     = valid_reg;
  assign overrun_o   = overrun_reg;
  assign frame_err_o = frame_err_reg;

endmodule

// File: tb/tb_iob_uart_rx_deser.sv
// Directed bench for iob_uart_rx_deser: serial frames driven bit by bit, expected bytes queued
// at send time and compared by a monitor whenever the DUT hands a byte over.
`timescale 1ns/1ps
module tb_iob_uart_rx_deser;

  logic        clk;
  logic        rst;
  logic        cke;
  logic        rx_en;
  logic [15:0] div;
  logic        rxd;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready;
  logic        clr;
  logic        overrun_o;
  logic        frame_err_o;
`ifdef IOB_UART_RX_PARITY_EN
  logic        par_en;
  logic        par_odd;
  logic        par_err_o;
`endif

  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          rise_cyc = 0;
  int          n_rises = 0;
  int          n_valid_cycles = 0;
  logic        valid_prev = 1'b0;
  logic [7:0]  sb_q[$];

  iob_uart_rx_deser dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cke_i       (cke),
    .rx_en_i     (rx_en),
    .div_i       (div),
    .rxd_i       (rxd),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready),
    .clr_i       (clr),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o)
`ifdef IOB_UART_RX_PARITY_EN
    ,
    .par_en_i    (par_en),
    .par_odd_i   (par_odd),
    .par_err_o   (par_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: one line per byte handed over, compared against the scoreboard head.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (valid_o && !valid_prev) begin
      rise_cyc = cyc;
      n_rises++;
    end
    valid_prev = valid_o;
    if (valid_o) n_valid_cycles++;
    if (valid_o && ready) begin
      check("sb_has_expected", (sb_q.size() != 0), 1'b1);
      if (sb_q.size() != 0) begin
        exp_b = sb_q.pop_front();
        $display("rx byte %02h expected %02h", data_o, exp_b);
        check("rx_data", data_o, exp_b);
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_cyc,
                            input logic with_par, input logic par_bit);
    @(negedge clk);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bit_cyc) @(negedge clk);
    end
    if (with_par) begin
      rxd = par_bit;
      repeat (bit_cyc) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (bit_cyc) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r0;
    int lat;
    rst = 1'b1; cke = 1'b1; rx_en = 1'b1; div = 16'd100; rxd = 1'b1;
    ready = 1'b1; clr = 1'b0;
`ifdef IOB_UART_RX_PARITY_EN
    par_en = 1'b0; par_odd = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data", data_o, 8'h00);
    check("reset_valid", valid_o, 1'b0);
    check("reset_overrun", overrun_o, 1'b0);
    check("reset_frame_err", frame_err_o, 1'b0);

    // Basic frame with latency measurement from start edge to valid_o rise.
    n_valid_cycles = 0;
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 100, 1'b0, 1'b0);
    lat = rise_cyc - start_cyc;
    n_checks++;
    assert (lat >= 948 && lat <= 958) else begin
      n_fails++;
      $error("FAIL start_to_valid_latency: observed %0d expected 948..958", lat);
    end
    check("valid_pulse_cycles", n_valid_cycles, 1);
    check("basic_overrun", overrun_o, 1'b0);
    check("basic_frame_err", frame_err_o, 1'b0);
    repeat (50) @(negedge clk);

    // Short low glitch must be rejected; the receiver still works afterwards.
    r0 = n_rises;
    @(negedge clk); rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_valid", n_rises, r0);
    check("glitch_valid_low", valid_o, 1'b0);
    sb_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 100, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("after_glitch_rx", n_rises, r0 + 1);

    // Overrun: two bytes back-to-back with nobody reading.
    @(posedge clk); #1 ready = 1'b0;
    send_frame(8'h00, 1'b1, 100, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 100, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("overrun_data_kept", data_o, 8'h00);
    check("overrun_valid", valid_o, 1'b1);
    check("overrun_flag", overrun_o, 1'b1);
    pulse_clr();
    check("overrun_cleared", overrun_o, 1'b0);
    check("overrun_valid_after_clr", valid_o, 1'b1);
    sb_q.push_back(8'h00);
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("valid_dropped_after_read", valid_o, 1'b0);

    // Framing error: byte dropped, flag sticky across a good frame.
    r0 = n_rises;
    send_frame(8'hA3, 1'b0, 100, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    check("frame_err_set", frame_err_o, 1'b1);
    check("frame_err_no_valid", n_rises, r0);
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 100, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err_sticky", frame_err_o, 1'b1);
    check("after_frame_err_rx", n_rises, r0 + 1);
    pulse_clr();
    check("frame_err_cleared", frame_err_o, 1'b0);

    // Reset in the middle of a frame with a byte pending at the output.
    @(posedge clk); #1 ready = 1'b0;
    send_frame(8'h42, 1'b1, 100, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("pending_before_reset", data_o, 8'h42);
    fork
      send_frame(8'h81, 1'b1, 100, 1'b0, 1'b0);
      begin
        repeat (450) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_data", data_o, 8'h00);
        check("midreset_valid", valid_o, 1'b0);
        check("midreset_overrun", overrun_o, 1'b0);
        check("midreset_frame_err", frame_err_o, 1'b0);
      end
    join
    @(posedge clk); #1 rst = 1'b0; ready = 1'b1;
    repeat (20) @(negedge clk);
    r0 = n_rises;
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 100, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("after_reset_rx", n_rises, r0 + 1);

    // Receiver disabled mid-frame: partial frame dropped.
    r0 = n_rises;
    fork
      send_frame(8'h5A, 1'b1, 100, 1'b0, 1'b0);
      begin
        repeat (500) @(negedge clk);
        @(posedge clk); #1 rx_en = 1'b0;
      end
    join
    @(posedge clk); #1 rx_en = 1'b1;
    repeat (50) @(negedge clk);
    check("rx_en_drop_no_valid", n_rises, r0);
    sb_q.push_back(8'hE7);
    send_frame(8'hE7, 1'b1, 100, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("after_rx_en_rx", n_rises, r0 + 1);

`ifdef IOB_UART_RX_PARITY_EN
    // Parity: wrong even parity flagged but byte still delivered, then a full sweep.
    @(posedge clk); #1 div = 16'd10; par_en = 1'b1; par_odd = 1'b0;
    sb_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 10, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("par_err_set", par_err_o, 1'b1);
    check("par_err_no_frame_err", frame_err_o, 1'b0);
    pulse_clr();
    check("par_err_cleared", par_err_o, 1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      logic       odd;
      b = i[7:0];
      odd = i[0];
      @(posedge clk); #1 par_odd = odd;
      sb_q.push_back(b);
      send_frame(b, 1'b1, 10, 1'b1, (^b) ^ odd);
    end
    repeat (30) @(negedge clk);
    check("sweep_par_err", par_err_o, 1'b0);
    check("sweep_frame_err", frame_err_o, 1'b0);
    check("sweep_overrun", overrun_o, 1'b0);
`endif

    repeat (20) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
